// File: rtl/pattern_sweep_pkg.sv
// Shared types, mode encodings and MISR step function for the pattern sweep engine.
package pattern_sweep_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, EMIT, DONE} sweep_state_t;

  localparam logic MODE_SWEEP  = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

  // Widest signature misr_next can handle; callers zero-extend into it.
  localparam int MISR_MAX_W = 64;

  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] data,
    input logic [MISR_MAX_W-1:0] poly,
    input int                    width
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] top;
    logic [MISR_MAX_W-1:0] nxt;
    mask = (width >= MISR_MAX_W) ? '1 : ((MISR_MAX_W'(1) << width) - MISR_MAX_W'(1));
    top  = sig >> (width - 1);
    nxt  = (sig << 1) ^ (top[0] ? poly : '0) ^ data;
    return nxt & mask;
  endfunction

endpackage

// File: rtl/sweep_misr.sv
// Multiple-input signature register: load seeds it, enable folds one response in.
// Single-cycle update; no flow control of its own.
module sweep_misr
  import pattern_sweep_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h002D,
  parameter int               OUT_W = 1,
  parameter logic [SIG_W-1:0] SEED  = '0
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [OUT_W-1:0] data,
  output logic [SIG_W-1:0] signature
);

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      signature <= '0;
    end else if (load) begin
      signature <= SEED;
    end else if (enable) begin
      signature <= SIG_W'(misr_next(MISR_MAX_W'(signature), MISR_MAX_W'(data),
                                    MISR_MAX_W'(POLY), SIG_W));
    end
  end

endmodule

// File: rtl/pattern_sweep_capture.sv
// Drives every (or one) IN_W-bit pattern into a DUT, captures its output after SETTLE cycles.
// One beat per >= SETTLE+1 cycles; a stalled resp_ready holds the beat and pauses the sweep.
module pattern_sweep_capture
  import pattern_sweep_pkg::*;
#(
  parameter int               IN_W     = 2,
  parameter int               OUT_W    = 1,
  parameter int               SETTLE   = 1,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] POLY     = 16'h002D,
  parameter logic [SIG_W-1:0] SIG_SEED = '0
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [IN_W-1:0]  pat_in,
  input  logic             abort,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [IN_W-1:0]  resp_pat,
  output logic [OUT_W-1:0] resp_data,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature
);

  localparam int              CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  sweep_state_t     state, state_next;
  logic [IN_W-1:0]  pattern;
  logic [CNT_W-1:0] settle_cnt;
  logic             mode_q;
  logic             launch, capture, advance, finish, quit;

  assign dut_in = pattern;

  always_ff @(posedge CK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    quit       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          launch     = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        if (abort) begin
          quit       = 1'b1;
          state_next = IDLE;
        end else if (settle_cnt == SETTLE_LAST) begin
          capture    = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        // abort wins over a handshake in the same cycle
        if (abort) begin
          quit       = 1'b1;
          state_next = IDLE;
        end else if (resp_valid && resp_ready) begin
          if (mode_q == MODE_SINGLE || &pattern) begin
            finish     = 1'b1;
            state_next = DONE;
          end else begin
            advance    = 1'b1;
            state_next = DRIVE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      pattern    <= '0;
      settle_cnt <= '0;
      mode_q     <= MODE_SWEEP;
      resp_valid <= 1'b0;
      resp_pat   <= '0;
      resp_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      busy <= (state_next == DRIVE) || (state_next == EMIT);
      done <= (state_next == DONE);

      if (launch) begin
        pattern    <= (mode == MODE_SWEEP) ? '0 : pat_in;
        settle_cnt <= '0;
        mode_q     <= mode;
      end else if (advance) begin
        pattern    <= pattern + 1'b1;
        settle_cnt <= '0;
      end else if (state == DRIVE) begin
        settle_cnt <= settle_cnt + 1'b1;
      end

      if (capture) begin
        resp_valid <= 1'b1;
        resp_pat   <= pattern;
        resp_data  <= dut_out;
      end else if (quit || advance || finish) begin
        resp_valid <= 1'b0;
      end
    end
  end

  sweep_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .OUT_W (OUT_W),
    .SEED  (SIG_SEED)
  ) u_misr (
    .CK        (CK),
    .reset     (reset),
    .load      (launch),
    .enable    (capture),
    .data      (dut_out),
    .signature (signature)
  );

endmodule

// File: tb/tb_pattern_sweep_capture.sv
// Bench: two engines (SETTLE=1 and SETTLE=3) driving XOR DUTs, run through a table of scenarios.
module tb_pattern_sweep_capture;

  typedef struct {
    logic [1:0] pat;
    logic       dat;
  } beat_t;

  typedef struct {
    logic       mode;
    logic [1:0] pat;
    int         stall_n;
    logic [1:0] stall_pat;
    logic       abort_en;
    logic [1:0] abort_pat;
    logic       reset_en;
    logic [1:0] reset_pat;
    logic       exp_done;
    logic [3:0] exp_sig;
  } vec_t;

  localparam int NV = 8;

  logic       CK;
  logic       start, mode;
  logic [1:0] pat_in;
  logic [1:0] rst, rdy, abt, rv, bsy, dn, dout, rdat;
  logic [1:0] din  [2];
  logic [1:0] rpat [2];
  logic [3:0] sig  [2];

  int n_pass, n_total;
  vec_t  vecs [NV];
  vec_t  cur;
  beat_t q0 [$];
  beat_t q1 [$];
  int    cyc [2];
  int    stall_left [2];
  logic  [1:0] rv_prev, stalled, fired, rst_fired;

  assign dout[0] = ^din[0];
  assign dout[1] = ^din[1];

  pattern_sweep_capture #(.IN_W(2), .OUT_W(1), .SETTLE(1), .SIG_W(4), .POLY(4'h3), .SIG_SEED(4'h0)) u_dut_s1 (
    .CK(CK), .reset(rst[0]), .start(start), .mode(mode), .pat_in(pat_in), .abort(abt[0]),
    .dut_in(din[0]), .dut_out(dout[0]), .resp_valid(rv[0]), .resp_ready(rdy[0]),
    .resp_pat(rpat[0]), .resp_data(rdat[0]), .busy(bsy[0]), .done(dn[0]), .signature(sig[0]));

  pattern_sweep_capture #(.IN_W(2), .OUT_W(1), .SETTLE(3), .SIG_W(4), .POLY(4'h3), .SIG_SEED(4'h0)) u_dut_s3 (
    .CK(CK), .reset(rst[1]), .start(start), .mode(mode), .pat_in(pat_in), .abort(abt[1]),
    .dut_in(din[1]), .dut_out(dout[1]), .resp_valid(rv[1]), .resp_ready(rdy[1]),
    .resp_pat(rpat[1]), .resp_data(rdat[1]), .busy(bsy[1]), .done(dn[1]), .signature(sig[1]));

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  function automatic int settle_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut_settle%0d: got %0h, expected %0h", name, settle_of(k), act, exp);
  endtask

  function automatic vec_t mk(logic m, logic [1:0] p, int sn, logic [1:0] sp, logic ae, logic [1:0] ap,
                              logic re, logic [1:0] rp, logic ed, logic [3:0] es);
    vec_t v;
    v.mode = m; v.pat = p; v.stall_n = sn; v.stall_pat = sp; v.abort_en = ae; v.abort_pat = ap;
    v.reset_en = re; v.reset_pat = rp; v.exp_done = ed; v.exp_sig = es;
    return v;
  endfunction

  function automatic void push_exp(int k, beat_t b);
    if (k == 0) q0.push_back(b);
    else        q1.push_back(b);
  endfunction

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic beat_t qfront(int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  function automatic beat_t qpop(int k);
    return (k == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  // Beats that will actually complete a handshake for this scenario.
  function automatic void push_run(vec_t c);
    beat_t b;
    logic [1:0] p;
    for (int i = 0; i < 4; i++) begin
      p = 2'(i);
      if (c.mode && p != c.pat) continue;
      if (c.abort_en && p == c.abort_pat) break;
      if (c.reset_en && p == c.reset_pat) break;
      b.pat = p;
      b.dat = ^p;
      for (int k = 0; k < 2; k++) push_exp(k, b);
    end
  endfunction

  // Per-engine consumer: drives ready/abort/reset at negedges and scores every beat.
  task automatic agent();
    beat_t b;
    logic [1:0] rst_now;
    forever begin
      @(negedge CK);
      rst_now = '0;
      for (int k = 0; k < 2; k++) begin
        if (rst_fired[k]) begin
          rst[k]       = 1'b0;
          rst_fired[k] = 1'b0;
        end
        cyc[k]++;
        abt[k] = 1'b0;
        if (rv[k] && !rv_prev[k]) check("valid_latency", k, cyc[k], settle_of(k) + 1);
        rv_prev[k] = rv[k];
        if (rv[k] && cur.stall_n > 0 && !stalled[k] && rpat[k] == cur.stall_pat) begin
          stalled[k]    = 1'b1;
          stall_left[k] = cur.stall_n;
        end
        if (stall_left[k] > 0) begin
          stall_left[k]--;
          rdy[k] = 1'b0;
          if (qsize(k) > 0) begin
            b = qfront(k);
            check("stall_valid", k, rv[k], 1);
            check("stall_pat", k, rpat[k], b.pat);
            check("stall_data", k, rdat[k], b.dat);
            check("stall_dut_in", k, din[k], b.pat);
          end
        end else begin
          rdy[k] = 1'b1;
        end
        if (rv[k] && rdy[k] && cur.abort_en && !fired[k] && rpat[k] == cur.abort_pat) begin
          abt[k]   = 1'b1;
          fired[k] = 1'b1;
        end
        if (rv[k] && cur.reset_en && !fired[k] && rpat[k] == cur.reset_pat) begin
          rst_now[k] = 1'b1;
          fired[k]   = 1'b1;
        end
        if (rv[k] && rdy[k] && !abt[k] && !rst_now[k]) begin
          if (qsize(k) == 0) begin
            check("unexpected_beat", k, {rpat[k], rdat[k]}, 0);
          end else begin
            b = qpop(k);
            check("beat_pat", k, rpat[k], b.pat);
            check("beat_data", k, rdat[k], b.dat);
          end
          cyc[k] = 0;
        end
        if (start && !bsy[k]) cyc[k] = 0;
      end
      if (|rst_now) begin
        rst = rst | rst_now;
        #1;
        for (int k = 0; k < 2; k++) begin
          if (rst_now[k]) begin
            check("rst_valid", k, rv[k], 0);
            check("rst_busy", k, bsy[k], 0);
            check("rst_done", k, dn[k], 0);
            check("rst_dut_in", k, din[k], 0);
            check("rst_pat_data", k, {rpat[k], rdat[k]}, 0);
            check("rst_sig", k, sig[k], 0);
            rst_fired[k] = 1'b1;
            rv_prev[k]   = 1'b0;
          end
        end
      end
    end
  endtask

  function automatic logic run_over(int k);
    return dn[k] || (fired[k] && !bsy[k]);
  endfunction

  initial begin
    int n;
    n_pass = 0; n_total = 0;
    start = 0; mode = 0; pat_in = 0;
    rst = '0; rdy = '1; abt = '0;
    rv_prev = '0; stalled = '0; fired = '0; rst_fired = '0;
    cyc[0] = 0; cyc[1] = 0; stall_left[0] = 0; stall_left[1] = 0;

    //          mode pat  stl  stlpat abt  abtpat rst  rstpat done sig
    vecs[0] = mk(0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 1, 4'h6);
    vecs[1] = mk(0, 2'd0, 5, 2'd1, 0, 2'd0, 0, 2'd0, 1, 4'h6);
    vecs[2] = mk(1, 2'd2, 0, 2'd0, 0, 2'd0, 0, 2'd0, 1, 4'h1);
    vecs[3] = mk(0, 2'd0, 0, 2'd0, 1, 2'd1, 0, 2'd0, 0, 4'h1);
    vecs[4] = mk(0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 1, 4'h6);
    vecs[5] = mk(0, 2'd0, 0, 2'd0, 0, 2'd0, 1, 2'd2, 0, 4'h0);
    vecs[6] = mk(0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 1, 4'h6);
    vecs[7] = mk(1, 2'd1, 0, 2'd0, 0, 2'd0, 0, 2'd0, 1, 4'h1);
    cur = vecs[0];

    #1 rst = 2'b11;
    #2;
    for (int k = 0; k < 2; k++) begin
      check("reset_valid", k, rv[k], 0);
      check("reset_busy_done", k, {bsy[k], dn[k]}, 0);
      check("reset_dut_in", k, din[k], 0);
      check("reset_pat_data", k, {rpat[k], rdat[k]}, 0);
      check("reset_sig", k, sig[k], 0);
    end
    @(posedge CK); #1 rst = '0;
    fork
      agent();
    join_none

    for (int v = 0; v < NV; v++) begin
      cur = vecs[v];
      fired = '0; stalled = '0;
      push_run(cur);
      @(posedge CK); #1 start = 1'b1; mode = cur.mode; pat_in = cur.pat;
      @(posedge CK); #1 start = 1'b0;
      n = 0;
      while (!(run_over(0) && run_over(1)) && n < 400) begin
        @(posedge CK); #1;
        n++;
      end
      repeat (3) @(posedge CK);
      #1;
      for (int k = 0; k < 2; k++) begin
        check("run_finished", k, run_over(k), 1);
        check("end_done", k, dn[k], cur.exp_done);
        check("end_sig", k, sig[k], cur.exp_sig);
        check("end_valid_busy", k, {rv[k], bsy[k]}, 0);
        check("beats_left", k, qsize(k), 0);
        if (cur.exp_done) check("end_dut_in", k, din[k], cur.mode ? cur.pat : 2'b11);
      end
      q0.delete();
      q1.delete();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
